jtframe_bank_arb: RTL and testbench

JTFRAME_BANK_ARB -- requirements
Module: jtframe_bank_arb

---
 rtl/jtframe_bank_arb.sv | 142 ++++++++++++++
 tb/tb_jtframe_bank_arb.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_bank_arb.sv
// Round-robin arbiter sharing one SDRAM bank read port among four clients.
// Define JTFRAME_BANK_ARB_TOUT_EN to add a watchdog and the sticky tout_err output.
module jtframe_bank_arb #(
  parameter int AW   = 22,
  parameter int TOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    cl_req,
  input  logic [4*AW-1:0] cl_addr,
  output logic [3:0]    cl_ack,
  output logic [3:0]    cl_dst,
  output logic [3:0]    cl_dok,
  output logic [3:0]    cl_rdy,
  output logic [AW-1:0] ba_addr,
  output logic          ba_rd,
  input  logic          ba_ack,
  input  logic          ba_dst,
  input  logic          ba_dok,
  input  logic          ba_rdy,
  output logic [1:0]    gnt,
`ifdef JTFRAME_BANK_ARB_TOUT_EN
  output logic          tout_err,
`endif
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_RDY} state_t;

  state_t        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          rd_q, rd_d;
  logic          tout;
  logic          done;
  logic [2:0]    pick_res;
  logic [3:0]    mask;

  // Returns {found, index} of the first requester at or after p, wrapping 3->0.
  function automatic logic [2:0] pick(input logic [3:0] req, input logic [1:0] p);
    logic [1:0] idx;
    pick = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = p + 2'(i);
      if (req[idx]) pick = {1'b1, idx};
    end
  endfunction

  assign pick_res = pick(cl_req, ptr_q);

`ifdef JTFRAME_BANK_ARB_TOUT_EN
  localparam int CW = $clog2(TOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  // Counter sits at zero in IDLE; ba_rd drops on the edge where it would reach TOUT.
  assign tout  = busy && (cnt_q == CW'(TOUT - 1));
  assign cnt_d = (state_q == IDLE) ? '0 : cnt_q + 1'b1;
  assign err_d = err_q | tout;
  assign tout_err = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`else
  assign tout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_res[2]) begin
          gnt_d   = pick_res[1:0];
          addr_d  = cl_addr[int'(pick_res[1:0])*AW +: AW];
          rd_d    = 1'b1;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ba_ack) begin
          rd_d = 1'b0;
          if (ba_rdy) done = 1'b1;
          else        state_d = WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        if (ba_rdy) done = 1'b1;
      end
      default: begin
        state_d = IDLE;
        rd_d    = 1'b0;
      end
    endcase
    if (tout) done = 1'b1;
    if (done) begin
      state_d = IDLE;
      rd_d    = 1'b0;
      ptr_d   = gnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      gnt_q   <= 2'd0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
    end
  end

  // Bank strobes are routed only to the granted client, and never while idle.
  assign busy    = (state_q != IDLE);
  assign mask    = busy ? (4'b0001 << gnt_q) : 4'b0000;
  assign cl_ack  = mask & {4{ba_ack}};
  assign cl_dst  = mask & {4{ba_dst}};
  assign cl_dok  = mask & {4{ba_dok}};
  assign cl_rdy  = mask & {4{ba_rdy | tout}};
  assign ba_addr = addr_q;
  assign ba_rd   = rd_q;
  assign gnt     = gnt_q;

endmodule

// File: tb/tb_jtframe_bank_arb.sv
// Directed scoreboard bench for jtframe_bank_arb (watchdog step runs when JTFRAME_BANK_ARB_TOUT_EN is defined).
module tb_jtframe_bank_arb;
  localparam int AW = 22;
`ifdef JTFRAME_BANK_ARB_TOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 255;
`endif

  logic          clk, rst_n;
  logic [3:0]    cl_req;
  logic [4*AW-1:0] cl_addr;
  logic [3:0]    cl_ack, cl_dst, cl_dok, cl_rdy;
  logic [AW-1:0] ba_addr;
  logic          ba_rd, ba_ack, ba_dst, ba_dok, ba_rdy;
  logic [1:0]    gnt;
  logic          busy;
`ifdef JTFRAME_BANK_ARB_TOUT_EN
  logic          tout_err;
`endif
  logic [AW-1:0] caddr [4];

  typedef struct { logic [1:0] g; logic [AW-1:0] a; } exp_t;
  exp_t sbq[$];
  int nchk = 0;
  int nerr = 0;

  assign cl_addr = {caddr[3], caddr[2], caddr[1], caddr[0]};

  jtframe_bank_arb #(.AW(AW), .TOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .cl_req(cl_req), .cl_addr(cl_addr),
    .cl_ack(cl_ack), .cl_dst(cl_dst), .cl_dok(cl_dok), .cl_rdy(cl_rdy),
    .ba_addr(ba_addr), .ba_rd(ba_rd), .ba_ack(ba_ack), .ba_dst(ba_dst),
    .ba_dok(ba_dok), .ba_rdy(ba_rdy), .gnt(gnt),
`ifdef JTFRAME_BANK_ARB_TOUT_EN
    .tout_err(tout_err),
`endif
    .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int g);
    exp_t e;
    e.g = 2'(g);
    e.a = caddr[g];
    sbq.push_back(e);
  endtask

  task automatic serve(input int ack_dly, input int rdy_dly, input bit together,
                       input int req_mid, input int exp_wait);
    exp_t e;
    int n;
    logic [1:0] g;
    n = 0;
    while (ba_rd !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("grant_latency", 32'(n), 32'(exp_wait));
    e = sbq.pop_front();
    g = e.g;
    chk("gnt", 32'(gnt), 32'(e.g));
    chk("ba_addr", 32'(ba_addr), 32'(e.a));
    chk("busy_grant", 32'(busy), 32'd1);
    repeat (ack_dly) begin
      tick();
      chk("rd_hold", 32'(ba_rd), 32'd1);
      chk("addr_hold", 32'(ba_addr), 32'(e.a));
    end
    ba_ack = 1'b1;
    ba_rdy = together;
    #1;
    chk("cl_ack", 32'(cl_ack), 32'd1 << g);
    chk("cl_rdy_w_ack", 32'(cl_rdy), together ? (32'd1 << g) : 32'd0);
    tick();
    ba_ack = 1'b0;
    ba_rdy = 1'b0;
    #1;
    chk("rd_off", 32'(ba_rd), 32'd0);
    chk("cl_ack_pulse", 32'(cl_ack), 32'd0);
    if (together) begin
      chk("idle_after_both", 32'(busy), 32'd0);
      chk("cl_rdy_pulse", 32'(cl_rdy), 32'd0);
    end else begin
      if (req_mid >= 0) cl_req = 4'(req_mid);
      repeat (rdy_dly) begin
        tick();
        chk("gnt_hold", 32'(gnt), 32'(g));
        chk("busy_rdy", 32'(busy), 32'd1);
        ba_dst = 1'b1;
        ba_dok = 1'b1;
        #1;
        chk("cl_dst", 32'(cl_dst), 32'd1 << g);
        chk("cl_dok", 32'(cl_dok), 32'd1 << g);
        chk("cl_rdy_early", 32'(cl_rdy), 32'd0);
        ba_dst = 1'b0;
        ba_dok = 1'b0;
      end
      ba_rdy = 1'b1;
      #1;
      chk("cl_rdy", 32'(cl_rdy), 32'd1 << g);
      tick();
      ba_rdy = 1'b0;
      #1;
      chk("idle_gap", 32'(busy), 32'd0);
      chk("cl_rdy_pulse", 32'(cl_rdy), 32'd0);
    end
  endtask

  initial begin
    exp_t e;
    int n;
    int rdy_at;
    caddr[0] = 22'h000abc;
    caddr[1] = 22'h001234;
    caddr[2] = 22'h02a5a5;
    caddr[3] = 22'h3ffff0;
    rst_n  = 1'b0;
    cl_req = 4'b0000;
    ba_ack = 1'b0; ba_dst = 1'b0; ba_dok = 1'b0; ba_rdy = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_ba_rd", 32'(ba_rd), 32'd0);
    chk("rst_ba_addr", 32'(ba_addr), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cl_all", 32'({cl_ack, cl_dst, cl_dok, cl_rdy}), 32'd0);
`ifdef JTFRAME_BANK_ARB_TOUT_EN
    chk("rst_tout_err", 32'(tout_err), 32'd0);
`endif
    rst_n = 1'b1;
    tick();

    // Single request from client 1; client drops its request early
    cl_req = 4'b0010;
    push(1);
    serve(2, 4, 1'b0, 0, 1);
    tick();
    chk("no_regrant", 32'(busy), 32'd0);

    // All clients requesting after reset: order 0,1,2,3,0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    cl_req = 4'b1111;
    push(0); push(1); push(2); push(3); push(0);
    repeat (5) serve(1, 1, 1'b0, -1, 1);
    cl_req = 4'b0000;

    // Client 0 requests during client 2's WAIT_RDY
    cl_req = 4'b0100;
    push(2);
    serve(1, 3, 1'b0, 4'b0101, 1);
    cl_req = 4'b0001;
    push(0);
    serve(1, 1, 1'b0, 0, 1);

    // ack and rdy in the same cycle
    cl_req = 4'b0010;
    push(1);
    serve(1, 0, 1'b1, -1, 1);
    cl_req = 4'b0000;
    tick();
    chk("idle_after_both2", 32'(busy), 32'd0);

    // Reset in WAIT_RDY, stray rdy afterwards, pointer back to 0
    cl_req = 4'b0100;
    push(2);
    tick();
    e = sbq.pop_front();
    chk("rst_case_gnt", 32'(gnt), 32'(e.g));
    ba_ack = 1'b1;
    tick();
    ba_ack = 1'b0;
    cl_req = 4'b0000;
    #1;
    chk("rst_case_wait_rdy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_gnt", 32'(gnt), 32'd0);
    chk("midrst_addr", 32'(ba_addr), 32'd0);
    chk("midrst_rd", 32'(ba_rd), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    ba_rdy = 1'b1;
    #1;
    chk("stray_rdy_masked", 32'(cl_rdy), 32'd0);
    tick();
    ba_rdy = 1'b0;
    #1;
    chk("stray_rdy_idle", 32'(busy), 32'd0);
    cl_req = 4'b1010;
    push(1);
    serve(1, 1, 1'b0, 0, 1);

`ifdef JTFRAME_BANK_ARB_TOUT_EN
    // Watchdog: ack never arrives
    cl_req = 4'b0100;
    tick();
    chk("wd_gnt", 32'(gnt), 32'd2);
    n = 0;
    rdy_at = -1;
    while (ba_rd === 1'b1 && n < 100) begin
      if (cl_rdy === 4'b0100) rdy_at = n;
      tick();
      n++;
    end
    cl_req = 4'b0000;
    chk("wd_rd_cycles", 32'(n), 32'd16);
    chk("wd_rdy_pulse_at", 32'(rdy_at), 32'd15);
    chk("wd_err", 32'(tout_err), 32'd1);
    chk("wd_idle", 32'(busy), 32'd0);
    chk("wd_rdy_off", 32'(cl_rdy), 32'd0);
    tick();
    chk("wd_err_sticky", 32'(tout_err), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
